// File: rtl/system_clken_gen.sv
// system_clken_gen: multi-channel phase-accumulator clock-enable generator with lock indication.
// Optional CLKEN_PHASE_RESET_EN clears a channel's accumulator when its increment is rewritten.
module system_clken_gen #(
    parameter int CHANNELS = 3,
    parameter int ACC_W = 32,
    parameter int LOCK_CYCLES = 16,
    parameter logic [CHANNELS*ACC_W-1:0] INIT_INC = '0
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic                cfg_ready,
    output logic [CHANNELS-1:0] outclk_en,
    output logic                locked
);
    localparam logic [15:0] LOCK_INIT = 16'(LOCK_CYCLES);

    logic [ACC_W-1:0] acc_q [CHANNELS];
    logic [ACC_W-1:0] acc_d [CHANNELS];
    logic [ACC_W-1:0] inc_q [CHANNELS];
    logic [ACC_W-1:0] inc_d [CHANNELS];
    logic [ACC_W:0] sum [CHANNELS];
    logic [CHANNELS-1:0] en_q, en_d, hit;
    logic ready_q, ready_d, wr, wr_ok;
    logic [15:0] lock_q, lock_d;

    always_comb begin
        wr = cfg_we && ready_q;
        wr_ok = wr && ({1'b0, cfg_ch} < 4'(CHANNELS));
        ready_d = !wr;
        lock_d = wr_ok ? LOCK_INIT : (lock_q != 16'd0 ? lock_q - 16'd1 : 16'd0);
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            en_d[i] = sum[i][ACC_W];
            hit[i] = wr_ok && (cfg_ch == 3'(i));
            inc_d[i] = hit[i] ? cfg_inc : inc_q[i];
`ifdef CLKEN_PHASE_RESET_EN
            acc_d[i] = hit[i] ? '0 : sum[i][ACC_W-1:0];
`else
            acc_d[i] = sum[i][ACC_W-1:0];
`endif
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INIT_INC[i*ACC_W +: ACC_W];
            end
            en_q <= '0;
            ready_q <= 1'b0;
            lock_q <= LOCK_INIT;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
            end
            en_q <= en_d;
            ready_q <= ready_d;
            lock_q <= lock_d;
        end
    end

    assign outclk_en = en_q;
    assign cfg_ready = ready_q;
    assign locked = (lock_q == 16'd0);
endmodule

// File: tb/tb_system_clken_gen.sv
// tb_system_clken_gen: randomized bench against a phase-arithmetic reference model.
module tb_system_clken_gen;
    localparam int CH = 3;
    localparam int LOCK = 16;
    localparam logic [95:0] INIT = {32'h0, 32'h0, 32'h8000_0000};
    localparam bit [63:0] MOD = 64'h1_0000_0000;

    logic refclk = 1'b0;
    logic rst = 1'b1;
    logic cfg_we = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [31:0] cfg_inc = '0;
    logic cfg_ready, locked;
    logic [CH-1:0] outclk_en;

    int n_checks = 0;
    int n_err = 0;

    bit [63:0] m_acc [CH];
    bit [63:0] m_inc [CH];
    bit [CH-1:0] m_en;
    bit m_ready;
    int m_since;

    system_clken_gen #(.CHANNELS(CH), .ACC_W(32), .LOCK_CYCLES(LOCK), .INIT_INC(INIT)) dut (
        .refclk(refclk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
        .cfg_ready(cfg_ready), .outclk_en(outclk_en), .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each channel's phase advances by inc mod 2^32; a pulse marks a wrap.
    task automatic model_step();
        bit acc_w, ok;
        bit [63:0] s;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_acc[c] = 0;
                m_inc[c] = 64'(INIT[c*32 +: 32]);
            end
            m_en = '0;
            m_ready = 0;
            m_since = 0;
        end else begin
            acc_w = cfg_we && m_ready;
            ok = acc_w && (cfg_ch < CH);
            for (int c = 0; c < CH; c++) begin
                s = m_acc[c] + m_inc[c];
                m_en[c] = (s >= MOD);
                m_acc[c] = s % MOD;
                if (ok && cfg_ch == c) begin
                    m_inc[c] = 64'(cfg_inc);
`ifdef CLKEN_PHASE_RESET_EN
                    m_acc[c] = 0;
`endif
                end
            end
            m_ready = !acc_w;
            m_since = ok ? 0 : (m_since < LOCK ? m_since + 1 : m_since);
        end
    endtask

    task automatic cyc(input logic r, input logic we, input logic [2:0] ch, input logic [31:0] inc);
        rst = r;
        cfg_we = we;
        cfg_ch = ch;
        cfg_inc = inc;
        @(posedge refclk);
        model_step();
        @(negedge refclk);
        chk("outclk_en", 32'(outclk_en), 32'(m_en));
        chk("locked", 32'(locked), 32'(m_since >= LOCK));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic write_when_ready(input logic [2:0] ch, input logic [31:0] inc);
        if (!m_ready) idle(1);
        cyc(1'b0, 1'b1, ch, inc);
    endtask

    initial begin
        @(negedge refclk);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 3'd1, 32'h1234);
        chk("rst_en", 32'(outclk_en), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        cyc(1'b0, 1'b0, 3'd0, 32'd0);
        chk("ready_after_release", 32'(cfg_ready), 32'd1);
        cyc(1'b0, 1'b0, 3'd0, 32'd0);
        chk("ch0_pulse_cycle2", 32'(outclk_en[0]), 32'd1);
        idle(16);
        chk("locked_after_release", 32'(locked), 32'd1);
        write_when_ready(3'd1, 32'h4000_0000);
        chk("ready_drop", 32'(cfg_ready), 32'd0);
        chk("locked_drop", 32'(locked), 32'd0);
        idle(20);
        write_when_ready(3'd5, 32'h7777_7777);
        chk("oor_locked_kept", 32'(locked), 32'd1);
        idle(4);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 3'd2, $urandom);
        idle(20);
        write_when_ready(3'd2, 32'hFFFF_FFFF);
        idle(12);
        write_when_ready(3'd2, 32'h0);
        idle(6);
        idle(1);
        write_when_ready(3'd0, 32'h8000_0000);
        idle(6);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0)
                cyc(1'b1, 1'($urandom_range(0, 1)), 3'($urandom), $urandom);
            else if ($urandom_range(0, 3) == 0)
                cyc(1'b0, 1'b1, 3'($urandom), ($urandom_range(0, 3) == 0) ? 32'h4000_0000 << $urandom_range(0, 1) : $urandom);
            else
                cyc(1'b0, 1'b0, 3'($urandom), $urandom);
        end
        cyc(1'b1, 1'b1, 3'd0, 32'h0);
        chk("rst_mid_en", 32'(outclk_en), 32'd0);
        chk("rst_mid_locked", 32'(locked), 32'd0);
        idle(24);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
